// File: rtl/fdiv_iter.sv
// fdiv_iter: multi-cycle FP32 divider, y = x1 / x2.
// Radix-2 restoring mantissa division, STEPS quotient bits per cycle.
// Truncating rounding, flush-to-zero on underflow, no denormals/NaN payloads.
// STEPS must divide 25 (1, 5 or 25).
module fdiv_iter #(
  parameter int STEPS = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] y,
  output logic        ovf
);

  localparam int N  = 25 / STEPS;
  localparam int CW = 5;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

  // special-case result kinds latched at acceptance
  localparam logic [1:0] SP_NONE = 2'd0;
  localparam logic [1:0] SP_INF  = 2'd1;
  localparam logic [1:0] SP_ZERO = 2'd2;

  state_t        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   y_q, y_d;
  logic          ovf_q, ovf_d;
  logic          sy_q, sy_d;
  logic [7:0]    e1_q, e1_d;
  logic [7:0]    e2_q, e2_d;
  logic [23:0]   mb_q, mb_d;
  logic [25:0]   rem_q, rem_d;
  logic [24:0]   quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    spec_q, spec_d;

  logic          accept;
  logic          last_step;
  logic [1:0]    spec_dec;
  logic [25:0]   rem_nx;
  logic [24:0]   quo_nx;
  logic [9:0]    exp_s;
  logic [22:0]   mant;

  assign accept    = (state_q == S_IDLE) && req_ready_q && req_valid;
  assign last_step = (cnt_q == CW'(N - 1));

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign y          = y_q;
  assign ovf        = ovf_q;

  // special-case decode of the raw operands, in priority order
  always_comb begin
    spec_dec = SP_NONE;
    if (x2[30:23] == 8'h00 || x1[30:23] == 8'hFF || x2[30:23] == 8'hFF)
      spec_dec = SP_INF;
    else if (x1[30:23] == 8'h00)
      spec_dec = SP_ZERO;
  end

  // STEPS restoring-division iterations resolved in one cycle
  always_comb begin
    rem_nx = rem_q;
    quo_nx = quo_q;
    for (int i = 0; i < STEPS; i++) begin
      if (rem_nx >= {2'b00, mb_q}) begin
        quo_nx = {quo_nx[23:0], 1'b1};
        rem_nx = rem_nx - {2'b00, mb_q};
      end else begin
        quo_nx = {quo_nx[23:0], 1'b0};
      end
      rem_nx = {rem_nx[24:0], 1'b0};
    end
  end

  // normalize: quotient is in (0.5,2), so at most one position of shift
  always_comb begin
    if (quo_q[24]) begin
      mant  = quo_q[23:1];
      exp_s = {2'b00, e1_q} - {2'b00, e2_q} + 10'd127;
    end else begin
      mant  = quo_q[22:0];
      exp_s = {2'b00, e1_q} - {2'b00, e2_q} + 10'd126;
    end
  end

  // state register and all datapath flops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      y_q          <= '0;
      ovf_q        <= 1'b0;
      sy_q         <= 1'b0;
      e1_q         <= '0;
      e2_q         <= '0;
      mb_q         <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      spec_q       <= SP_NONE;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      y_q          <= y_d;
      ovf_q        <= ovf_d;
      sy_q         <= sy_d;
      e1_q         <= e1_d;
      e2_q         <= e2_d;
      mb_q         <= mb_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      cnt_q        <= cnt_d;
      spec_q       <= spec_d;
    end
  end

  // next-state logic; special cases skip straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (spec_dec != SP_NONE) ? S_DONE : S_DIV;
      S_DIV:  if (last_step) state_d = S_NORM;
      S_NORM: state_d = S_DONE;
      S_DONE: if (resp_valid_q && resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath and handshake outputs per state
  always_comb begin
    req_ready_d  = 1'b0;
    resp_valid_d = resp_valid_q;
    y_d          = y_q;
    ovf_d        = ovf_q;
    sy_d         = sy_q;
    e1_d         = e1_q;
    e2_d         = e2_q;
    mb_d         = mb_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    cnt_d        = cnt_q;
    spec_d       = spec_q;
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          sy_d        = x1[31] ^ x2[31];
          e1_d        = x1[30:23];
          e2_d        = x2[30:23];
          mb_d        = {1'b1, x2[22:0]};
          rem_d       = {2'b01, x1[22:0], 1'b0} >> 1;
          quo_d       = '0;
          cnt_d       = '0;
          spec_d      = spec_dec;
        end
      end
      S_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = last_step ? '0 : cnt_q + 1'b1;
      end
      S_NORM: begin
        resp_valid_d = 1'b1;
        if ($signed(exp_s) <= 0) begin
          y_d   = {sy_q, 31'h0};
          ovf_d = 1'b0;
        end else if ($signed(exp_s) >= 255) begin
          y_d   = {sy_q, 8'hFF, 23'h0};
          ovf_d = 1'b1;
        end else begin
          y_d   = {sy_q, exp_s[7:0], mant};
          ovf_d = 1'b0;
        end
      end
      S_DONE: begin
        if (spec_q != SP_NONE && !resp_valid_q) begin
          // special result lands one edge after acceptance
          resp_valid_d = 1'b1;
          spec_d       = SP_NONE;
          if (spec_q == SP_INF) begin
            y_d   = {sy_q, 8'hFF, 23'h0};
            ovf_d = 1'b1;
          end else begin
            y_d   = {sy_q, 31'h0};
            ovf_d = 1'b0;
          end
        end else if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
